// File: rtl/io_bus_master.sv
// Single-access initiator for the memory-mapped peripheral bus, with an optional
// periodic switch-to-7-seg mirror sequence that runs without a CPU.
module io_bus_master #(
  parameter int unsigned ACC_CYCLES     = 1,
  parameter logic        WE_STORE_LEVEL = 1'b0,
  parameter logic [31:0] SW_ADDR        = 32'hFFFF_FFF0,
  parameter logic [31:0] SEG_ADDR       = 32'hFFFF_FFF8,
  parameter int unsigned POLL_PERIOD    = 1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  input  logic        poll_en,
  output logic        busy,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        WE,
  output logic        MREQ,
  input  logic [31:0] IO_Data
);

  localparam int unsigned CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int unsigned TMR_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);
  localparam logic             WE_IDLE  = ~WE_STORE_LEVEL;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_RESP,
    ST_P_RD,
    ST_P_WR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      a_nxt, wd_nxt, rsp_data_nxt;
  logic             we_nxt, mreq_nxt, rsp_valid_nxt;
  logic [TMR_W-1:0] poll_tmr;
  logic             poll_pend;
  logic             poll_launch;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next values of every registered bus/response output
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    a_nxt         = A;
    wd_nxt        = WD;
    we_nxt        = WE;
    mreq_nxt      = MREQ;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    poll_launch   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_nxt     = cmd_addr;
          wd_nxt    = cmd_we ? cmd_wdata : 32'h0;
          we_nxt    = cmd_we ? WE_STORE_LEVEL : WE_IDLE;
          mreq_nxt  = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_ACC;
        end else if (poll_pend && poll_en) begin
          poll_launch = 1'b1;
          a_nxt       = SW_ADDR;
          wd_nxt      = 32'h0;
          we_nxt      = WE_IDLE;
          mreq_nxt    = 1'b1;
          cnt_nxt     = CNT_LOAD;
          state_nxt   = ST_P_RD;
        end
      end

      ST_ACC: begin
        if (cnt == '0) begin
          // WE still carries the command direction during the access
          rsp_data_nxt  = (WE == WE_STORE_LEVEL) ? 32'h0 : IO_Data;
          rsp_valid_nxt = 1'b1;
          mreq_nxt      = 1'b0;
          we_nxt        = WE_IDLE;
          state_nxt     = ST_RESP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end

      ST_P_RD: begin
        if (cnt == '0) begin
          // WD holds the captured switch value for the whole write phase
          a_nxt     = SEG_ADDR;
          wd_nxt    = IO_Data;
          we_nxt    = WE_STORE_LEVEL;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_P_WR;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_P_WR: begin
        if (cnt == '0) begin
          mreq_nxt  = 1'b0;
          we_nxt    = WE_IDLE;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        mreq_nxt  = 1'b0;
        we_nxt    = WE_IDLE;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs and access counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt       <= '0;
      A         <= 32'h0;
      WD        <= 32'h0;
      WE        <= WE_IDLE;
      MREQ      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      A         <= a_nxt;
      WD        <= wd_nxt;
      WE        <= we_nxt;
      MREQ      <= mreq_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  // Poll timer: counts idle cycles; a new expiry takes priority over the launch clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      poll_tmr  <= '0;
      poll_pend <= 1'b0;
    end else if (!poll_en) begin
      poll_tmr  <= '0;
      poll_pend <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (poll_tmr == TMR_LAST) begin
        poll_tmr  <= '0;
        poll_pend <= 1'b1;
      end else begin
        poll_tmr <= poll_tmr + 1'b1;
        if (poll_launch) begin
          poll_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: transaction-level model, peripheral with
// switch and 7-seg registers, per-cycle compare plus literal expectations.
`timescale 1ns/1ps
module tb_io_bus_master;

  localparam int unsigned ACC   = 2;
  localparam int unsigned PER   = 8;
  localparam logic [31:0] SW_A  = 32'hFFFF_FFF0;
  localparam logic [31:0] SEG_A = 32'hFFFF_FFF8;

  localparam int M_IDLE = 0;
  localparam int M_CMD  = 1;
  localparam int M_RESP = 2;
  localparam int M_POLL = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        poll_en, busy;
  logic [31:0] A, WD;
  logic        WE, MREQ;
  logic [31:0] IO_Data;

  // Second instance used only for the mid-access reset case
  logic        nrst_r, cmd_valid_r;
  logic        r_cmd_ready, r_rsp_valid, r_busy, r_WE, r_MREQ;
  logic [31:0] r_rsp_data, r_A, r_WD;

  logic [31:0] sw_reg, seg_reg;
  int          checks   = 0;
  int          failures = 0;
  int          mreq_cyc = 0;

  io_bus_master #(
    .ACC_CYCLES(ACC), .WE_STORE_LEVEL(1'b0), .SW_ADDR(SW_A),
    .SEG_ADDR(SEG_A), .POLL_PERIOD(PER)
  ) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .poll_en(poll_en), .busy(busy), .A(A), .WD(WD), .WE(WE), .MREQ(MREQ),
    .IO_Data(IO_Data)
  );

  io_bus_master #(
    .ACC_CYCLES(3), .WE_STORE_LEVEL(1'b0), .SW_ADDR(SW_A),
    .SEG_ADDR(SEG_A), .POLL_PERIOD(PER)
  ) dut_r (
    .clk(clk), .nrst(nrst_r), .cmd_valid(cmd_valid_r), .cmd_ready(r_cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(r_rsp_valid), .rsp_ready(1'b0), .rsp_data(r_rsp_data),
    .poll_en(1'b0), .busy(r_busy), .A(r_A), .WD(r_WD), .WE(r_WE), .MREQ(r_MREQ),
    .IO_Data(32'h1234_5678)
  );

  always #5 clk = ~clk;

  // Peripheral: switch register, 7-seg register, other addresses return a pattern
  always_comb begin
    if (A == SW_A)       IO_Data = sw_reg;
    else if (A == SEG_A) IO_Data = seg_reg;
    else                 IO_Data = A ^ 32'hA5A5_0000;
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) seg_reg <= 32'h0;
    else if (MREQ && !WE && A == SEG_A) seg_reg <= WD;
  end

  always @(negedge clk) if (MREQ === 1'b1) mreq_cyc = mreq_cyc + 1;

  function automatic logic [31:0] periph_rd(input logic [31:0] a);
    if (a == SW_A)  return sw_reg;
    if (a == SEG_A) return seg_reg;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: mode, remaining request cycles, expected outputs
  int          m_mode, m_left;
  int unsigned m_timer;
  logic        m_pend, m_we, m_mreq, m_rv, m_wr, m_wrap, m_launch;
  logic [31:0] m_a, m_wd, m_rd;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_mode = M_IDLE; m_left = 0; m_timer = 0; m_pend = 1'b0;
      m_a = 32'h0; m_wd = 32'h0; m_rd = 32'h0;
      m_we = 1'b1; m_mreq = 1'b0; m_rv = 1'b0; m_wr = 1'b0;
    end else begin
      m_wrap   = 1'b0;
      m_launch = (m_mode == M_IDLE) && !cmd_valid && m_pend && poll_en;
      if (!poll_en) begin
        m_timer = 0;
        m_pend  = 1'b0;
      end else if (m_mode == M_IDLE) begin
        m_wrap  = (m_timer == PER - 1);
        m_timer = m_wrap ? 0 : m_timer + 1;
      end
      case (m_mode)
        M_IDLE: begin
          if (cmd_valid) begin
            m_mode = M_CMD; m_left = ACC; m_a = cmd_addr; m_wr = cmd_we;
            m_wd = cmd_we ? cmd_wdata : 32'h0; m_we = !cmd_we; m_mreq = 1'b1;
          end else if (m_launch) begin
            m_mode = M_POLL; m_left = 2 * ACC; m_a = SW_A; m_wd = 32'h0;
            m_we = 1'b1; m_mreq = 1'b1; m_pend = 1'b0;
          end
        end
        M_CMD: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_rd = m_wr ? 32'h0 : periph_rd(m_a);
            m_rv = 1'b1; m_mreq = 1'b0; m_we = 1'b1; m_mode = M_RESP;
          end
        end
        M_RESP: begin
          if (rsp_ready) begin
            m_rv = 1'b0; m_mode = M_IDLE;
          end
        end
        default: begin
          m_left = m_left - 1;
          if (m_left == ACC) begin
            m_a = SEG_A; m_wd = sw_reg; m_we = 1'b0;
          end else if (m_left == 0) begin
            m_mreq = 1'b0; m_we = 1'b1; m_mode = M_IDLE;
          end
        end
      endcase
      if (m_wrap) m_pend = 1'b1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == M_IDLE));
    chk("busy",      32'(busy),      32'(m_mode != M_IDLE));
    chk("MREQ",      32'(MREQ),      32'(m_mreq));
    chk("WE",        32'(WE),        32'(m_we));
    chk("A",         A,              m_a);
    chk("WD",        WD,             m_wd);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_data",  rsp_data,       m_rd);
  end

  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int stall, output logic [31:0] data, output int lat);
    int n;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n = n + 1;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat = lat + 1;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    data = rsp_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      chk("stall_mreq",  32'(MREQ),      32'd0);
      chk("stall_data",  rsp_data,       data);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_seg(input logic [31:0] v, input string nm);
    int n;
    n = 0;
    while (seg_reg !== v && n < 80) begin
      @(posedge clk); #1; n = n + 1;
    end
    chk(nm, seg_reg, v);
  endtask

  initial begin
    logic [31:0] d;
    int lat, n;
    nrst = 1'b0; nrst_r = 1'b0; cmd_valid = 1'b0; cmd_valid_r = 1'b0;
    cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; poll_en = 1'b0; sw_reg = 32'h5A;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mreq",  32'(MREQ),      32'd0);
    chk("rst_we",    32'(WE),        32'd1);
    chk("rst_a",     A,              32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp",   32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1; nrst_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Read of the switch register
    mreq_cyc = 0;
    do_cmd(1'b0, SW_A, 32'hDEAD_BEEF, 0, d, lat);
    chk("rd_sw_data",     d,        32'h5A);
    chk("rd_latency",     32'(lat), 32'd2);
    chk("rd_mreq_cycles", 32'(mreq_cyc), 32'd2);

    // Write to the 7-seg register, display 1/2/3
    do_cmd(1'b1, SEG_A, 32'h7B, 0, d, lat);
    chk("wr_rsp_zero", d,                        32'h0);
    chk("seg_val",     seg_reg,                  32'h7B);
    chk("seg_d2",      (seg_reg / 100) % 10,     32'd1);
    chk("seg_d1",      (seg_reg / 10) % 10,      32'd2);
    chk("seg_d0",      seg_reg % 10,             32'd3);

    // Response back-pressure for 5 cycles
    do_cmd(1'b0, 32'h0000_0100, 32'h0, 5, d, lat);
    chk("stall_rd_data", d, 32'hA5A5_0100);

    // Poll mirror: switch 200 appears on the display as 2/0/0
    sw_reg = 32'd200;
    poll_en = 1'b1;
    wait_seg(32'd200, "poll_seg");
    chk("poll_d2", (seg_reg / 100) % 10, 32'd2);
    chk("poll_d1", (seg_reg / 10) % 10,  32'd0);
    chk("poll_d0", seg_reg % 10,         32'd0);

    // Command arriving on the poll-due cycle runs first
    n = 0;
    while (!(m_pend && m_mode == M_IDLE) && n < 60) begin
      @(posedge clk); #1; n = n + 1;
    end
    chk("due_found", 32'(m_pend), 32'd1);
    sw_reg = 32'h33;
    do_cmd(1'b0, 32'h0000_0040, 32'h0, 0, d, lat);
    chk("due_cmd_first", d, 32'hA5A5_0040);
    @(posedge clk); #1;
    chk("due_poll_mreq", 32'(MREQ), 32'd1);
    chk("due_poll_addr", A,         SW_A);
    wait_seg(32'h33, "due_poll_seg");
    poll_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Async reset in the second access cycle of a 3-cycle access
    cmd_we = 1'b0; cmd_addr = 32'h10; cmd_valid_r = 1'b1;
    @(posedge clk); #1;
    cmd_valid_r = 1'b0;
    chk("r_mreq_c1", 32'(r_MREQ), 32'd1);
    @(posedge clk); #1;
    chk("r_mreq_c2", 32'(r_MREQ), 32'd1);
    #2;
    nrst_r = 1'b0;
    #1;
    chk("r_rst_mreq", 32'(r_MREQ),      32'd0);
    chk("r_rst_rsp",  32'(r_rsp_valid), 32'd0);
    @(posedge clk); #1;
    nrst_r = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("r_ready_after", 32'(r_cmd_ready), 32'd1);
    chk("r_no_rsp",      32'(r_rsp_valid), 32'd0);
    chk("r_idle_mreq",   32'(r_MREQ),      32'd0);
    chk("r_not_busy",    32'(r_busy),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
